dtree_node_loader: RTL and testbench
====================================

Name: dtree_node_loader

Overview:
Byte-serial configuration writer for the decision-tree classifier's node memory. It accepts a stream of configuration bytes over a valid/ready handshake and assembles them into NODE_SIZE-bit node words. It issues one write per node, in address order, on the classifier's wr_node/node_addr/node_data_in port, then checks a trailing XOR checksum byte. It sits between the host/SPI byte interface and the classifier, and owns the whole node-load sequence after reset.

Parameters:
FEATURES, 3, features per node (same meaning as in the classifier)
COEFF_WIDTH, 4, coefficient width
BIAS_WIDTH, 4, bias width
MAX_CLUSTERS, 5, nodes per channel
CHANNEL_COUNT, 1, channels
(derived) NODE_SIZE = 2+FEATURES+(FEATURES-1)*COEFF_WIDTH+BIAS_WIDTH+1 (default 18)
(derived) NODE_BYTES = ceil(NODE_SIZE/8) (default 3)
(derived) NODES = MAX_CLUSTERS*CHANNEL_COUNT; ADDR_W = max(1, clog2(NODES))

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low; logic held in reset while reset==0
restart  in  1  synchronous pulse; abort/restart load sequence
byte_valid  in  1  byte_data valid
byte_ready  out  1  loader accepts byte this cycle
byte_data  in  8  configuration byte
wr_node  out  1  one-cycle node write strobe to classifier
node_addr  out  ADDR_W  node index being written (classifier uses low clog2(MAX_CLUSTERS) bits)
node_data_in  out  NODE_SIZE  assembled node word
load_done  out  1  high from checksum acceptance until restart/reset
csum_err  out  1  valid while load_done; 1 = checksum mismatch

Behaviour:
- Reset (reset==0, async): state LOAD, byte_cnt=0, node_cnt=0, xor_acc=0, wr_node=0, node_addr=0, node_data_in=0, load_done=0, csum_err=0. byte_ready=1 once reset releases.
- Handshake: a byte is accepted on a rising edge with byte_valid & byte_ready. byte_ready = (state==LOAD | state==CHECK) & ~restart. Combinational, with no dependency on byte_valid.
- States:
  LOAD: each accepted byte k (0..NODE_BYTES-1) is written to node_data_in bits [8k+7:8k]; bits at or above NODE_SIZE are discarded. xor_acc ^= byte. byte_cnt increments. Acceptance of byte NODE_BYTES-1 -> WRITE, byte_cnt=0.
  WRITE (exactly 1 cycle): wr_node=1, node_addr=node_cnt, node_data_in stable, byte_ready=0. Next edge: node_cnt+1. If node_cnt==NODES-1 -> CHECK, else -> LOAD.
  CHECK: accepts one byte. csum_err <= (byte != xor_acc), load_done <= 1, then -> DONE.
  DONE: byte_ready=0, wr_node=0. Outputs hold until restart.
- Latency: wr_node asserts in the cycle immediately after the last byte of a node is accepted. load_done asserts in the cycle after the checksum byte is accepted.
- Bytes may arrive back-to-back. The only stall is the one WRITE cycle per node.
- node_data_in and node_addr hold their last written values outside WRITE. They are not cleared between nodes; each byte overwrites its own slice.
- restart==1 in any state: next state LOAD; byte_cnt, node_cnt, xor_acc, load_done and csum_err cleared; wr_node=0 that cycle and after. restart has priority over a concurrent byte, which is dropped because byte_ready is forced low. A WRITE pending in that cycle is not issued.
- The classifier's node counter advances only by reset. A mid-load restart must therefore be paired with a classifier reset by the system. The loader does not track this itself.
- byte_valid while byte_ready==0: ignored; the byte is not consumed.
- Checksum is the XOR of all NODES*NODE_BYTES data bytes, full 8 bits, including discarded pad bits.

Test Plan:
- Defaults, bytes 0x01..0x0F back-to-back, then checksum 0x00 -> 5 wr_node pulses at addr 0..4; node0 data 0x30201, node4 data 0x30E0D; load_done=1, csum_err=0.
- Same stream, checksum 0x55 -> load_done=1, csum_err=1, still exactly 5 writes.
- byte_valid toggled 1/0 each cycle -> identical writes and data; byte_ready low exactly in each WRITE cycle and in DONE.
- restart asserted with byte_valid=1 after byte 7 -> byte dropped, no wr_node; then full 16-byte reload -> writes addr 0..4, csum_err=0.
- reset pulled low mid-node (after 2 bytes of node 2), released -> all outputs at reset values; next write is addr 0.
- Extra bytes offered in DONE -> byte_ready=0, no wr_node, load_done and csum_err unchanged.

Source files
------------

// File: rtl/dtree_node_loader.sv
// Byte-serial loader for the decision-tree node memory: packs configuration bytes
// into node words, writes them in address order, then verifies a trailing XOR checksum.
module dtree_node_loader #(
  parameter int FEATURES      = 3,
  parameter int COEFF_WIDTH   = 4,
  parameter int BIAS_WIDTH    = 4,
  parameter int MAX_CLUSTERS  = 5,
  parameter int CHANNEL_COUNT = 1,
  localparam int NODE_SIZE  = 2 + FEATURES + (FEATURES - 1) * COEFF_WIDTH + BIAS_WIDTH + 1,
  localparam int NODE_BYTES = (NODE_SIZE + 7) / 8,
  localparam int NODES      = MAX_CLUSTERS * CHANNEL_COUNT,
  localparam int ADDR_W     = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic [7:0]           byte_data,
  output logic                 wr_node,
  output logic [ADDR_W-1:0]    node_addr,
  output logic [NODE_SIZE-1:0] node_data_in,
  output logic                 load_done,
  output logic                 csum_err
);

  localparam int BCNT_W = (NODE_BYTES > 1) ? $clog2(NODE_BYTES) : 1;

  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_CHECK, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [BCNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]     node_cnt_q, node_cnt_d;
  logic [7:0]            xor_q, xor_d;
  logic [NODE_SIZE-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  load_done_q, load_done_d;
  logic                  csum_err_q, csum_err_d;
  logic                  accept;

  assign byte_ready   = ((state_q == S_LOAD) || (state_q == S_CHECK)) && !restart;
  assign wr_node      = (state_q == S_WRITE) && !restart;
  assign accept       = byte_valid && byte_ready;
  assign node_addr    = addr_q;
  assign node_data_in = data_q;
  assign load_done    = load_done_q;
  assign csum_err     = csum_err_q;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    node_cnt_d  = node_cnt_q;
    xor_d       = xor_q;
    data_d      = data_q;
    addr_d      = addr_q;
    load_done_d = load_done_q;
    csum_err_d  = csum_err_q;

    if (restart) begin
      // Node word and address are left as-is; only sequencing state restarts.
      state_d     = S_LOAD;
      byte_cnt_d  = '0;
      node_cnt_d  = '0;
      xor_d       = '0;
      load_done_d = 1'b0;
      csum_err_d  = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            xor_d = xor_q ^ byte_data;
            // Byte k lands on bits [8k+7:8k]; bits past the node width are dropped.
            for (int b = 0; b < NODE_SIZE; b++) begin
              if ((b / 8) == int'(byte_cnt_q)) begin
                data_d[b] = byte_data[b % 8];
              end
            end
            if (byte_cnt_q == BCNT_W'(NODE_BYTES - 1)) begin
              byte_cnt_d = '0;
              addr_d     = node_cnt_q;
              state_d    = S_WRITE;
            end else begin
              byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            end
          end
        end
        S_WRITE: begin
          node_cnt_d = node_cnt_q + ADDR_W'(1);
          state_d    = (node_cnt_q == ADDR_W'(NODES - 1)) ? S_CHECK : S_LOAD;
        end
        S_CHECK: begin
          if (accept) begin
            csum_err_d  = (byte_data != xor_q);
            load_done_d = 1'b1;
            state_d     = S_DONE;
          end
        end
        default: begin
          state_d = S_DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      byte_cnt_q  <= '0;
      node_cnt_q  <= '0;
      xor_q       <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      load_done_q <= 1'b0;
      csum_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      node_cnt_q  <= node_cnt_d;
      xor_q       <= xor_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      load_done_q <= load_done_d;
      csum_err_q  <= csum_err_d;
    end
  end

endmodule

// File: tb/tb_dtree_node_loader.sv
// Scoreboard bench for dtree_node_loader: stimulus queues expected writes and checksum
// verdicts, a negedge monitor pops and compares them as the DUT presents them.
module tb_dtree_node_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        restart;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        wr_node;
  logic [2:0]  node_addr;
  logic [17:0] node_data_in;
  logic        load_done;
  logic        csum_err;

  dtree_node_loader dut (
    .clk          (clk),
    .reset        (reset),
    .restart      (restart),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .byte_data    (byte_data),
    .wr_node      (wr_node),
    .node_addr    (node_addr),
    .node_data_in (node_data_in),
    .load_done    (load_done),
    .csum_err     (csum_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  addr;
    logic [17:0] data;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  wr_t  exp_wr_q[$];
  logic exp_csum_q[$];
  logic done_prev = 1'b0;
  bit   ready_audit = 1'b0;
  wr_t  mon_e;
  logic mon_c;

  // Hand-packed node words for the byte stream 0x01..0x0F (byte2 keeps only bits 1:0).
  logic [17:0] node_exp [5] = '{18'h30201, 18'h20504, 18'h10807, 18'h00B0A, 18'h30E0D};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (wr_node) begin
      wr_cnt++;
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%05h expected no write", node_addr, node_data_in);
      end else begin
        mon_e = exp_wr_q.pop_front();
        $display("write addr %0d data 0x%05h (expect addr %0d data 0x%05h)", node_addr, node_data_in, mon_e.addr, mon_e.data);
        chk("wr_addr", 32'(node_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(node_data_in), 32'(mon_e.data));
        chk("ready_in_write", 32'(byte_ready), 32'd0);
      end
    end
    if (load_done && !done_prev) begin
      if (exp_csum_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got load_done 1 expected 0");
      end else begin
        mon_c = exp_csum_q.pop_front();
        $display("load_done csum_err %0d (expect %0d)", csum_err, mon_c);
        chk("csum_err", 32'(csum_err), 32'(mon_c));
      end
    end
    if (ready_audit) begin
      chk("ready_idle", 32'(byte_ready), (wr_node || load_done || restart) ? 32'd0 : 32'd1);
    end
    done_prev = load_done;
  end

  task automatic push_nodes(input int first, input int last);
    wr_t e;
    for (int i = first; i <= last; i++) begin
      e.addr = 3'(i);
      e.data = node_exp[i];
      exp_wr_q.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok = 1'b0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      if (byte_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: got no acceptance of 0x%02h expected within 20 cycles", b);
    end
    if (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      if (load_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got load_done 0 expected 1 within 40 cycles");
    end
    @(negedge clk);
  endtask

  task automatic load_stream(input bit gap, input logic [7:0] csum, input logic exp_err);
    push_nodes(0, 4);
    exp_csum_q.push_back(exp_err);
    wr_cnt = 0;
    for (int i = 1; i <= 15; i++) send_byte(8'(i), gap);
    send_byte(csum, gap);
    wait_done();
    chk("write_count", 32'(wr_cnt), 32'd5);
    chk("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    chk("csum_queue_empty", 32'(exp_csum_q.size()), 32'd0);
    chk("load_done", 32'(load_done), 32'd1);
    chk("csum_err_hold", 32'(csum_err), 32'(exp_err));
    chk("ready_in_done", 32'(byte_ready), 32'd0);
  endtask

  task automatic do_restart(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    restart    = 1'b1;
    byte_valid = with_byte;
    byte_data  = b;
    #1;
    chk("ready_restart", 32'(byte_ready), 32'd0);
    chk("wr_restart", 32'(wr_node), 32'd0);
    @(negedge clk);
    restart    = 1'b0;
    byte_valid = 1'b0;
    #1;
    chk("done_cleared", 32'(load_done), 32'd0);
    chk("err_cleared", 32'(csum_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    restart    = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr_node", 32'(wr_node), 32'd0);
    chk("rst_node_addr", 32'(node_addr), 32'd0);
    chk("rst_node_data", 32'(node_data_in), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_csum_err", 32'(csum_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_byte_ready", 32'(byte_ready), 32'd1);

    // Back-to-back stream with correct checksum.
    load_stream(1'b0, 8'h00, 1'b0);

    // Extra bytes offered in DONE are ignored.
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk("ready_extra", 32'(byte_ready), 32'd0);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    #1;
    chk("done_extra", 32'(load_done), 32'd1);
    chk("err_extra", 32'(csum_err), 32'd0);
    do_restart(1'b0, 8'h00);

    // Wrong checksum.
    load_stream(1'b0, 8'h55, 1'b1);
    do_restart(1'b0, 8'h00);

    // Toggled byte_valid with byte_ready audited every cycle.
    ready_audit = 1'b1;
    load_stream(1'b1, 8'h00, 1'b0);
    do_restart(1'b0, 8'h00);
    ready_audit = 1'b0;

    // Restart with a byte offered after byte 7: byte dropped, no further write.
    push_nodes(0, 1);
    for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b0);
    do_restart(1'b1, 8'h08);
    repeat (3) @(negedge clk);
    chk("restart_wr_queue", 32'(exp_wr_q.size()), 32'd0);

    // Restart landing on a pending WRITE cycle suppresses that write.
    for (int i = 1; i <= 3; i++) send_byte(8'(i), 1'b0);
    do_restart(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    load_stream(1'b0, 8'h00, 1'b0);
    do_restart(1'b0, 8'h00);

    // Asynchronous reset after two bytes of node 2.
    push_nodes(0, 1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    reset      = 1'b0;
    #1;
    chk("midrst_wr_node", 32'(wr_node), 32'd0);
    chk("midrst_node_addr", 32'(node_addr), 32'd0);
    chk("midrst_node_data", 32'(node_data_in), 32'd0);
    chk("midrst_load_done", 32'(load_done), 32'd0);
    chk("midrst_csum_err", 32'(csum_err), 32'd0);
    chk("midrst_wr_queue", 32'(exp_wr_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_byte_ready", 32'(byte_ready), 32'd1);
    load_stream(1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
